// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding selector.
//   NLANE    : issue width (lanes per bundle)
//   NSTAGE   : number of in-flight result stages tracked
//   NENTRY   : total tracked results, which is also the result-mux width
//   SEL_NONE : select code meaning "read the register file"
//   fwd_entry_t : one tracked result {valid, dst, load}
package fwd_pkg;

  localparam int unsigned NLANE  = 4;
  localparam int unsigned NSTAGE = 3;
  localparam int unsigned NENTRY = NLANE * NSTAGE;

  localparam logic [3:0] SEL_NONE = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       load;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority search of the in-flight result table for one source operand.
// Ports:
//   entries    : flattened table, index = stage*NLANE + lane (stage 0 youngest)
//   q_valid    : query active
//   q_src      : source register queried
//   q_sel      : winning entry index, or SEL_NONE
//   q_hit      : a forwarding source was found
//   load_stall : winner is a load still in stage 0 (value not yet available)
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int unsigned NLANE  = fwd_pkg::NLANE,
  parameter int unsigned NSTAGE = fwd_pkg::NSTAGE
) (
  input  fwd_entry_t [NSTAGE*NLANE-1:0] entries,
  input  logic                          q_valid,
  input  logic [4:0]                    q_src,
  output logic [3:0]                    q_sel,
  output logic                          q_hit,
  output logic                          load_stall
);

  localparam int unsigned IW = (NSTAGE * NLANE > 1) ? $clog2(NSTAGE * NLANE) : 1;

  logic [IW-1:0] idx;

  // Entries are visited from lowest to highest priority (oldest stage first, lane 0 first
  // within a stage), so the last match seen is the winner.
  always_comb begin
    q_sel      = SEL_NONE;
    q_hit      = 1'b0;
    load_stall = 1'b0;
    idx        = '0;
    if (q_valid && (q_src != 5'd0)) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        for (int unsigned l = 0; l < NLANE; l++) begin
          idx = IW'((NSTAGE - 1 - k) * NLANE + l);
          if (entries[idx].valid && (entries[idx].dst == q_src)) begin
            q_sel      = 4'(idx);
            q_hit      = 1'b1;
            load_stall = (k == NSTAGE - 1) && entries[idx].load;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_select.sv
// Forwarding-source selector: tracks the destinations of in-flight results and, for each
// source-operand query, picks the youngest producer as a select code for the result mux.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   advance     : pipeline moves one stage this cycle
//   flush       : discard all in-flight entries
//   issue_*     : issuing bundle (valid, write-enable, load, destination per lane)
//   q_valid/src : source-operand queries
//   q_sel/q_hit : per-query mux select (SEL_NONE if none) and hit flag
//   stall       : some query depends on a load still in stage 0
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned NLANE  = fwd_pkg::NLANE,
  parameter int unsigned NSTAGE = fwd_pkg::NSTAGE,
  parameter int unsigned NQ     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [NLANE-1:0]      issue_valid,
  input  logic [NLANE-1:0]      issue_wen,
  input  logic [NLANE-1:0]      issue_load,
  input  logic [NLANE-1:0][4:0] issue_dst,
  input  logic [NQ-1:0]         q_valid,
  input  logic [NQ-1:0][4:0]    q_src,
  output logic [NQ-1:0][3:0]    q_sel,
  output logic [NQ-1:0]         q_hit,
  output logic                  stall
);

  // Flat table, index = stage*NLANE + lane, so the low NLANE entries are stage 0.
  fwd_entry_t [NSTAGE*NLANE-1:0] ent_q, ent_d;
  fwd_entry_t [NLANE-1:0]        new_stage;
  logic       [NQ-1:0]           load_stall;

  assign stall = |load_stall;

  // A stalled bundle enters as a bubble; x0 writes are never forwarded.
  for (genvar l = 0; l < NLANE; l++) begin : g_new
    assign new_stage[l].valid = issue_valid[l] & issue_wen[l] & (issue_dst[l] != 5'd0) & ~stall;
    assign new_stage[l].dst   = issue_dst[l];
    assign new_stage[l].load  = issue_load[l];
  end

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = '0;
    end else if (advance) begin
      // Shifting the flat vector up by one stage drops the oldest stage.
      ent_d = {ent_q[(NSTAGE-1)*NLANE-1:0], new_stage};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  for (genvar q = 0; q < NQ; q++) begin : g_q
    fwd_lookup #(
      .NLANE  (NLANE),
      .NSTAGE (NSTAGE)
    ) u_lookup (
      .entries    (ent_q),
      .q_valid    (q_valid[q]),
      .q_src      (q_src[q]),
      .q_sel      (q_sel[q]),
      .q_hit      (q_hit[q]),
      .load_stall (load_stall[q])
    );
  end

endmodule

// File: tb/tb_fwd_select.sv
// Self-checking bench for fwd_select: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the result table.
module tb_fwd_select;

  localparam int NLANE  = 4;
  localparam int NSTAGE = 3;
  localparam int NQ     = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  advance;
  logic                  flush;
  logic [NLANE-1:0]      issue_valid;
  logic [NLANE-1:0]      issue_wen;
  logic [NLANE-1:0]      issue_load;
  logic [NLANE-1:0][4:0] issue_dst;
  logic [NQ-1:0]         q_valid;
  logic [NQ-1:0][4:0]    q_src;
  logic [NQ-1:0][3:0]    q_sel;
  logic [NQ-1:0]         q_hit;
  logic                  stall;

  int checks   = 0;
  int failures = 0;

  // Model: what each in-flight slot currently holds.
  bit         m_v [NSTAGE][NLANE];
  logic [4:0] m_d [NSTAGE][NLANE];
  bit         m_l [NSTAGE][NLANE];

  fwd_select #(
    .NLANE  (NLANE),
    .NSTAGE (NSTAGE),
    .NQ     (NQ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_load  (issue_load),
    .issue_dst   (issue_dst),
    .q_valid     (q_valid),
    .q_src       (q_src),
    .q_sel       (q_sel),
    .q_hit       (q_hit),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Youngest producer wins: rank by age first, then by program order within a bundle.
  function automatic void model_find(input logic qv, input logic [4:0] src,
                                     output logic [3:0] sel, output logic hit,
                                     output logic st0load);
    int best = -1;
    int bs   = 0;
    int bl   = 0;
    sel     = 4'hF;
    hit     = 1'b0;
    st0load = 1'b0;
    if (qv && src != 5'd0) begin
      for (int s = 0; s < NSTAGE; s++) begin
        for (int l = 0; l < NLANE; l++) begin
          if (m_v[s][l] && m_d[s][l] == src) begin
            int score = (NSTAGE - s) * 100 + l;
            if (score > best) begin
              best = score;
              bs   = s;
              bl   = l;
            end
          end
        end
      end
    end
    if (best >= 0) begin
      sel     = 4'(bs * 4 + bl);
      hit     = 1'b1;
      st0load = (bs == 0) && m_l[bs][bl];
    end
  endfunction

  function automatic logic model_stall();
    logic [3:0] s;
    logic       h, ld;
    logic       any = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      model_find(q_valid[q], q_src[q], s, h, ld);
      any |= ld;
    end
    return any;
  endfunction

  task automatic check_all();
    logic [3:0] s;
    logic       h, ld;
    for (int q = 0; q < NQ; q++) begin
      model_find(q_valid[q], q_src[q], s, h, ld);
      chk($sformatf("q_sel[%0d]", q), q_sel[q], s);
      chk($sformatf("q_hit[%0d]", q), {3'b0, q_hit[q]}, {3'b0, h});
    end
    chk("stall", {3'b0, stall}, {3'b0, model_stall()});
  endtask

  task automatic model_edge();
    logic st = model_stall();
    if (reset || flush) begin
      for (int s = 0; s < NSTAGE; s++)
        for (int l = 0; l < NLANE; l++) m_v[s][l] = 1'b0;
    end else if (advance) begin
      for (int s = NSTAGE - 1; s >= 1; s--) begin
        for (int l = 0; l < NLANE; l++) begin
          m_v[s][l] = m_v[s-1][l];
          m_d[s][l] = m_d[s-1][l];
          m_l[s][l] = m_l[s-1][l];
        end
      end
      for (int l = 0; l < NLANE; l++) begin
        m_v[0][l] = !st && issue_valid[l] && issue_wen[l] && issue_dst[l] != 5'd0;
        m_d[0][l] = issue_dst[l];
        m_l[0][l] = issue_load[l];
      end
    end
  endtask

  // One clock: compare at the falling edge, update the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_issue();
    issue_valid = '0;
    issue_wen   = '0;
    issue_load  = '0;
    issue_dst   = '0;
  endtask

  task automatic issue(input int lane, input logic [4:0] dst, input logic ld);
    issue_valid[lane] = 1'b1;
    issue_wen[lane]   = 1'b1;
    issue_load[lane]  = ld;
    issue_dst[lane]   = dst;
  endtask

  task automatic expect_now(input string tag, input int q, input logic [3:0] sel,
                            input logic hit, input logic st);
    #1;
    chk({tag, ".sel"}, q_sel[q], sel);
    chk({tag, ".hit"}, {3'b0, q_hit[q]}, {3'b0, hit});
    chk({tag, ".stall"}, {3'b0, stall}, {3'b0, st});
  endtask

  initial begin
    for (int s = 0; s < NSTAGE; s++)
      for (int l = 0; l < NLANE; l++) begin
        m_v[s][l] = 1'b0;
        m_d[s][l] = '0;
        m_l[s][l] = 1'b0;
      end
    reset   = 1'b1;
    advance = 1'b0;
    flush   = 1'b0;
    q_valid = '0;
    q_src   = '0;
    clear_issue();
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    reset = 1'b0;

    // Empty table: nothing to forward.
    q_valid[0] = 1'b1;
    q_src[0]   = 5'd5;
    expect_now("reset_q5", 0, 4'hF, 1'b0, 1'b0);
    step();

    // A single producer ages through the stages and then falls out.
    issue(2, 5'd5, 1'b0);
    advance = 1'b1;
    step();
    clear_issue();
    advance = 1'b0;
    expect_now("age_s0", 0, 4'h2, 1'b1, 1'b0);
    advance = 1'b1;
    step();
    step();
    expect_now("age_s2", 0, 4'hA, 1'b1, 1'b0);
    step();
    expect_now("age_out", 0, 4'hF, 1'b0, 1'b0);
    advance = 1'b0;

    // Higher lane wins within a bundle; a younger stage beats an older one.
    issue(1, 5'd7, 1'b0);
    issue(3, 5'd7, 1'b0);
    advance = 1'b1;
    step();
    clear_issue();
    advance  = 1'b0;
    q_src[0] = 5'd7;
    expect_now("lane_prio", 0, 4'h3, 1'b1, 1'b0);
    issue(0, 5'd7, 1'b0);
    advance = 1'b1;
    step();
    clear_issue();
    advance = 1'b0;
    expect_now("stage_prio", 0, 4'h0, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_now("flushed", 0, 4'hF, 1'b0, 1'b0);

    // Load in stage 0 stalls; the stalled bundle (lane1 dst 9) must be squashed.
    issue(0, 5'd9, 1'b1);
    advance = 1'b1;
    step();
    clear_issue();
    advance  = 1'b0;
    q_src[0] = 5'd9;
    expect_now("load_s0", 0, 4'h0, 1'b1, 1'b1);
    issue(1, 5'd9, 1'b0);
    advance = 1'b1;
    step();
    clear_issue();
    advance = 1'b0;
    expect_now("load_s1", 0, 4'h4, 1'b1, 1'b0);

    // Reset during a stall clears it on the next cycle.
    issue(3, 5'd9, 1'b1);
    advance = 1'b1;
    step();
    clear_issue();
    advance = 1'b0;
    expect_now("stall_pre_rst", 0, 4'h3, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_now("stall_post_rst", 0, 4'hF, 1'b0, 1'b0);

    // x0 is never forwarded; flush with advance discards the table and the bundle.
    issue(0, 5'd0, 1'b0);
    issue(1, 5'd12, 1'b0);
    advance = 1'b1;
    step();
    clear_issue();
    advance    = 1'b0;
    q_src[0]   = 5'd0;
    q_valid[1] = 1'b1;
    q_src[1]   = 5'd12;
    expect_now("src_zero", 0, 4'hF, 1'b0, 1'b0);
    expect_now("dst12", 1, 4'h1, 1'b1, 1'b0);
    issue(2, 5'd12, 1'b0);
    flush   = 1'b1;
    advance = 1'b1;
    step();
    clear_issue();
    flush   = 1'b0;
    advance = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      q_valid[q] = 1'b1;
      q_src[q]   = 5'(q + 5);
    end
    q_src[1] = 5'd12;
    for (int q = 0; q < NQ; q++) expect_now("flush_adv", q, 4'hF, 1'b0, 1'b0);

    // Random traffic over a small register range so matches are frequent.
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 49) == 0);
      flush   = ($urandom_range(0, 19) == 0);
      advance = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < NLANE; l++) begin
        issue_valid[l] = 1'($urandom_range(0, 1));
        issue_wen[l]   = ($urandom_range(0, 3) != 0);
        issue_load[l]  = ($urandom_range(0, 3) == 0);
        issue_dst[l]   = 5'($urandom_range(0, 7));
      end
      for (int q = 0; q < NQ; q++) begin
        q_valid[q] = ($urandom_range(0, 3) != 0);
        q_src[q]   = 5'($urandom_range(0, 7));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_select.md
FWD_SELECT -- requirements
Module: fwd_select

Interface
REQ-001 SHALL have parameter NLANE, default 4, issue width (lanes per bundle).
REQ-002 SHALL have parameter NSTAGE, default 3, in-flight result stages tracked; NLANE*NSTAGE SHALL equal 12.
REQ-003 SHALL have parameter NQ, default 8, source-operand query ports (rs/rt per lane).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 advance  input  1  pipeline moves one stage this cycle.
REQ-007 flush  input  1  discard all in-flight entries.
REQ-008 issue_valid  input  NLANE  lane holds an instruction in the issuing bundle.
REQ-009 issue_wen  input  NLANE  lane writes a register.
REQ-010 issue_load  input  NLANE  lane is a load.
REQ-011 issue_dst  input  NLANE x 5  destination register per lane.
REQ-012 q_valid  input  NQ  query port active.
REQ-013 q_src  input  NQ x 5  source register per query.
REQ-014 q_sel  output  NQ x 4  select code for the 12:1 result mux, or SEL_NONE (4'hF).
REQ-015 q_hit  output  NQ  forwarding source found; 0 means read register file.
REQ-016 stall  output  1  a query depends on a load still in stage 0.

Function
REQ-017 SHALL hold a registered table of NSTAGE x NLANE entries {valid, dst, load}; stage 0 youngest.
REQ-018 On advance=1, flush=0: stage k+1 <- stage k for all k; stage NSTAGE-1 contents discarded.
REQ-019 On advance=1, stall=0: stage 0 <- issue bundle; entry valid = issue_valid & issue_wen & (issue_dst != 0).
REQ-020 On advance=1, stall=1: stage 0 <- all-invalid bubble; older stages still advance.
REQ-021 On advance=0, flush=0: table SHALL hold unchanged.
REQ-022 flush=1 SHALL invalidate every entry next cycle regardless of advance; issue inputs ignored.
REQ-023 Lookup SHALL be combinational from the registered table and current q_src; table updates visible one cycle after the capturing edge.
REQ-024 Match: valid entry with dst == q_src, q_valid=1, q_src != 0.
REQ-025 Priority: lower stage wins; within a stage, higher lane index wins (later in program order).
REQ-026 q_sel SHALL equal stage*4 + lane of the winning entry (range 0..11); q_hit=1.
REQ-027 No match, q_valid=0, or q_src=0: q_sel=4'hF, q_hit=0.
REQ-028 stall SHALL be 1 iff some query's winning entry is in stage 0 with load=1; a load in stage >=1 SHALL forward without stall.
REQ-029 RAW hazards within a single issue bundle SHALL NOT be detected; the issue stage guarantees none.

Reset
REQ-030 reset=1 SHALL invalidate all entries at the next edge; reset overrides flush and advance.
REQ-031 After reset: q_sel=4'hF and q_hit=0 for every port; stall=0.
REQ-032 Reset asserted mid-stall SHALL clear stall the following cycle.

Structure
REQ-033 Package fwd_pkg SHALL hold NLANE, NSTAGE, SEL_NONE=4'hF, and the entry struct typedef {valid, dst[4:0], load}.
REQ-034 One sub-module fwd_lookup SHALL implement the per-query priority search; fwd_select instantiates it NQ times.

Verification
REQ-035 Reset, then q_src[0]=5, q_valid[0]=1 -> q_hit[0]=0, q_sel[0]=4'hF, stall=0.
REQ-036 Issue lane2 dst=5 non-load, advance=1; next cycle q_src=5 -> q_sel=4'h2; after two more advances -> 4'hA; one more advance -> 4'hF.
REQ-037 Same bundle lane1 and lane3 both dst=7 -> q_sel=4'h3; next bundle lane0 dst=7 after advance -> q_sel=4'h0 (stage 0 beats stage 1).
REQ-038 Lane0 load dst=9, advance; query 9 -> stall=1, q_sel=4'h0; advance with stall -> stage 0 bubble, q_sel=4'h4, stall=0.
REQ-039 Issue dst=0 with wen=1 -> query 0 returns q_hit=0; flush and advance in the same cycle -> all queries q_sel=4'hF next cycle.
